// File: rtl/mfp_ahb_lite_arbiter2_if.sv
// AHB-Lite single-transfer bus bundle shared by the master-facing ports and the
// slave-facing port of the two-master arbiter.
interface mfp_ahb_lite_arbiter2_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    // Handshake: an address phase is taken on a rising edge where HSEL,
    // HTRANS[1] and HREADY are all high; the data phase that follows ends on
    // the first rising edge with HREADY high, and the next address phase may
    // be presented in that same cycle.
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/mfp_ahb_lite_arbiter2.sv
// Two-master AHB-Lite arbiter: latches each master's address phase, then replays
// it as a single NONSEQ on the shared slave, stalling the master until done.
module mfp_ahb_lite_arbiter2 #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                           HCLK,
    input  logic                           HRESETn,
    mfp_ahb_lite_arbiter2_if.slave         m0,
    mfp_ahb_lite_arbiter2_if.slave         m1,
    mfp_ahb_lite_arbiter2_if.master        s,
    output logic [1:0]                     dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic [1:0]  state;
    logic        gnt;
    logic        last;
    logic [1:0]  pend_valid;
    logic [1:0]  pend_write;
    logic [31:0] pend_addr [2];
    logic [2:0]  pend_size [2];
    logic [1:0]  done;
    logic [1:0]  hready;
    logic [1:0]  cap;
    logic        pick;
    logic [31:0] s_addr_q;
    logic        s_write_q;
    logic [2:0]  s_size_q;

    // done[m] marks master m's completion cycle on the slave side.
    assign done[0] = (state == S_DATA) && s.HREADY && !gnt;
    assign done[1] = (state == S_DATA) && s.HREADY && gnt;
    assign hready  = ~pend_valid | done;
    assign cap[0]  = m0.HSEL && m0.HTRANS[1] && hready[0];
    assign cap[1]  = m1.HSEL && m1.HTRANS[1] && hready[1];

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_valid <= 2'b00;
            pend_write <= 2'b00;
            for (int m = 0; m < 2; m++) begin
                pend_addr[m] <= 32'h0;
                pend_size[m] <= 3'b000;
            end
        end else begin
            if (cap[0]) begin
                pend_valid[0] <= 1'b1;
                pend_addr[0]  <= m0.HADDR;
                pend_write[0] <= m0.HWRITE;
                pend_size[0]  <= m0.HSIZE;
            end else if (done[0]) begin
                pend_valid[0] <= 1'b0;
            end
            if (cap[1]) begin
                pend_valid[1] <= 1'b1;
                pend_addr[1]  <= m1.HADDR;
                pend_write[1] <= m1.HWRITE;
                pend_size[1]  <= m1.HSIZE;
            end else if (done[1]) begin
                pend_valid[1] <= 1'b0;
            end
        end
    end

    // On a tie, round-robin favours the master that was not served last.
    always_comb begin
        pick = 1'b0;
        if (pend_valid == 2'b11) begin
            pick = (FIXED_PRIORITY != 0) ? 1'b0 : ~last;
        end else begin
            pick = pend_valid[1];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            gnt       <= 1'b0;
            last      <= 1'b1;
            s_addr_q  <= 32'h0;
            s_write_q <= 1'b0;
            s_size_q  <= 3'b000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|pend_valid) begin
                        gnt       <= pick;
                        s_addr_q  <= pend_addr[pick];
                        s_write_q <= pend_write[pick];
                        s_size_q  <= pend_size[pick];
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (s.HREADY) state <= S_DATA;
                end
                S_DATA: begin
                    if (s.HREADY) begin
                        last  <= gnt;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign s.HSEL    = (state == S_ADDR);
    assign s.HTRANS  = (state == S_ADDR) ? 2'b10 : 2'b00;
    assign s.HADDR   = s_addr_q;
    assign s.HWRITE  = s_write_q;
    assign s.HSIZE   = s_size_q;
    assign s.HBURST  = 3'b000;
    assign s.HWDATA  = gnt ? m1.HWDATA : m0.HWDATA;

    assign m0.HRDATA = s.HRDATA;
    assign m1.HRDATA = s.HRDATA;
    assign m0.HREADY = hready[0];
    assign m1.HREADY = hready[1];
    assign m0.HRESP  = done[0] & s.HRESP;
    assign m1.HRESP  = done[1] & s.HRESP;

    assign dbg_state = state;

endmodule

// File: doc/mfp_ahb_lite_arbiter2.md
# mfp_ahb_lite_arbiter2

Two-master AHB-Lite arbiter placed in front of a single shared AHB-Lite slave, typically a wait-state RAM controller that throttles transfers with HREADY.
- Each master port behaves as an ordinary AHB-Lite slave toward its master.
- The block latches each master's address phase, grants the slave bus to one pending request at a time, and replays the transfer on the slave side as a single NONSEQ.
- It stalls the losing master with HREADY low until its transfer completes.

## Interface
Parameters:
- FIXED_PRIORITY, 0, 0 = round-robin; 1 = M0 always wins when both are pending.

Ports (clock and reset):
- HCLK  in  1  system clock; all state updates on its rising edge.
- HRESETn  in  1  asynchronous, active-low reset.

Ports (master side, each for m in {0,1}):
- Mm_HSEL  in  1  slave select from the master-side decoder.
- Mm_HADDR  in  32  address.
- Mm_HTRANS  in  2  transfer type.
- Mm_HWRITE  in  1  write flag.
- Mm_HSIZE  in  3  transfer size.
- Mm_HWDATA  in  32  write data; valid during the master's data phase.
- Mm_HRDATA  out  32  read data; equals S_HRDATA.
- Mm_HREADY  out  1  transfer-complete / stall indication to master m.
- Mm_HRESP  out  1  S_HRESP during master m's completion cycle, else 0.

Ports (slave side):
- S_HSEL  out  1  slave select.
- S_HADDR  out  32  address.
- S_HTRANS  out  2  transfer type.
- S_HWRITE  out  1  write flag.
- S_HSIZE  out  3  transfer size.
- S_HBURST  out  3  constant 3'b000 (SINGLE).
- S_HWDATA  out  32  write data, muxed from the granted master.
- S_HRDATA  in  32  read data from the slave.
- S_HREADY  in  1  slave ready.
- S_HRESP  in  1  slave response.

## Operation
Capture:
- Pending register per master: valid, addr, write, size.
- Load condition: Mm_HSEL && Mm_HTRANS[1] && Mm_HREADY. NONSEQ and SEQ are both accepted; IDLE and BUSY are ignored.
- A load sets pend_m.valid on the next edge.
- pend_m.valid clears on the edge that ends master m's completion cycle, unless a new capture occurs in that same cycle, in which case it reloads.

Mm_HREADY:
- 1 when pend_m.valid = 0.
- 1 in master m's completion cycle.
- 0 otherwise.

Arbitration FSM:
- State register: S_IDLE, S_ADDR, S_DATA; grant register gnt; last-served register last.
- S_IDLE:
  - If any pend valid, load gnt and go to S_ADDR.
  - Only one pending: that master wins.
  - Both pending: round-robin picks the master ≠ last; FIXED_PRIORITY=1 picks M0.
- S_ADDR: drive S_HSEL=1, S_HTRANS=2'b10 and address/control from pend_gnt. If S_HREADY=1, go to S_DATA; otherwise stay and hold all address-phase outputs stable.
- S_DATA: S_HTRANS=2'b00, S_HSEL=0, S_HWDATA=M(gnt)_HWDATA. If S_HREADY=1, this is the completion cycle for gnt: last<=gnt, then go to S_IDLE. Otherwise stay.

Outside S_ADDR:
- S_HTRANS=2'b00, S_HSEL=0.
- S_HADDR, S_HWRITE, S_HSIZE hold the last granted values.

Reset (asynchronous; also applies mid-transfer):
- State=S_IDLE, both pend.valid=0, gnt=0, last=1 (M0 wins the first tie).
- Outputs: Mm_HREADY=1, Mm_HRESP=0, S_HSEL=0, S_HTRANS=2'b00, S_HADDR=0, S_HWRITE=0, S_HSIZE=0.
- Any in-flight transfer is abandoned.

## Timing
- Capture in cycle T → S_IDLE sees the pending request at T+1 → slave address phase at T+2 → earliest completion at T+3.
- Minimum of 2 master wait states with a zero-wait slave.
- Each added slave wait state adds one cycle.
- A completion cycle may carry a new capture from the same master (pipelined address phase).
- While the other master is pending, round-robin serves the other master next.
- Worst-case stall for a master under round-robin with both continuously requesting: one foreign transfer plus its own.
- Mm_HRDATA and Mm_HRESP are combinational from the slave; HREADY per master is combinational from state, gnt and S_HREADY.

## Test plan
- Single M0 read, addr 0x10, zero-wait slave returning 0xDEADBEEF: S_HTRANS=NONSEQ at T+2; M0_HREADY low at T+1 and T+2; high at T+3 with M0_HRDATA=0xDEADBEEF.
- M1 write of 0xA5A5A5A5 to 0x24 into a slave with 2 wait states: S_HWDATA=0xA5A5A5A5 throughout S_DATA; M1_HREADY high only at T+5; slave memory word 9 = 0xA5A5A5A5.
- M0 and M1 capture in the same cycle, FIXED_PRIORITY=0, after reset: M0 served first, then M1; both see exactly one completion. Repeat with M1 having been served last → M0 served first again.
- Both masters issue back-to-back pipelined reads for 8 transfers each: grants strictly alternate and no transfer is lost or duplicated. With FIXED_PRIORITY=1, all 8 M0 transfers complete before any M1 transfer.
- HTRANS=BUSY or HSEL=0 on M0: nothing captured, M0_HREADY stays 1, S_HTRANS stays IDLE.
- HRESETn asserted during S_DATA with slave stalling: immediately S_HSEL=0, both HREADY=1, pending cleared. After release, a fresh M1 read completes normally at T+3.
